// File: rtl/mac_sched.sv
// -----------------------------------------------------------------------------
// mac_sched -- round-robin scheduler sharing one 8x8 multiply / 16-bit
// accumulate datapath among NREQ requesters.
//
// A requester raises req with a job length on its len slot. The scheduler
// grants one requester at a time (round robin from the pointer), clears the
// accumulator, accepts len operand pairs on the shared valid/ready bus and
// returns a one-cycle tagged result strobe.
//
// Ports:
//   clk        rising-edge clock
//   aclr_n     asynchronous reset, active low
//   req        per-requester job request (level, sampled only when idle)
//   len        per-requester job length, requester i at [i*LEN_W +: LEN_W]
//   gnt        one-hot grant, high from CLEAR through DONE
//   busy       high whenever the scheduler is not idle
//   op_a/op_b  unsigned operand pair from the granted requester
//   op_valid   operand pair valid
//   op_ready   scheduler accepts a pair this cycle
//   res_valid  one-cycle result strobe
//   res_data   accumulated result (held until the next result)
//   res_id     index of the requester owning the result (held)
//   res_ovf    accumulator wrapped during the job (held)
// -----------------------------------------------------------------------------

// Round-robin pick: first set req bit at or above ptr, else the first set bit
// below ptr. Two passes avoid a modulo on a variable index.
module mac_sched_arb #(
    parameter int NREQ  = 4,
    parameter int LEN_W = 8,
    parameter int ID_W  = 2
) (
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*LEN_W-1:0] len,
    input  logic [ID_W-1:0]       ptr,
    output logic                  found,
    output logic [ID_W-1:0]       idx,
    output logic [LEN_W-1:0]      sel_len
);
    // NOTE: every variable written here gets a default before any branch;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        found   = 1'b0;
        idx     = '0;
        sel_len = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i] && (ID_W'(i) >= ptr)) begin
                found   = 1'b1;
                idx     = ID_W'(i);
                sel_len = len[i*LEN_W +: LEN_W];
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i] && (ID_W'(i) < ptr)) begin
                found   = 1'b1;
                idx     = ID_W'(i);
                sel_len = len[i*LEN_W +: LEN_W];
            end
        end
    end
endmodule

// Multiply-accumulate datapath. acc_next/ovf_next expose the value the
// accumulator takes on an accepted beat, so the result can be captured in the
// same cycle as the last product without an extra pipeline stage.
module mac_sched_dp #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             aclr_n,
    input  logic             clear,
    input  logic             en,
    input  logic [7:0]       a,
    input  logic [7:0]       b,
    output logic [15:0]      acc,
    output logic             ovf,
    output logic [CNT_W-1:0] count,
    output logic [15:0]      acc_next,
    output logic             ovf_next
);
    logic [15:0] prod;
    logic [16:0] sum;

    always_comb begin
        prod     = 16'(a) * 16'(b);
        sum      = {1'b0, acc} + {1'b0, prod};
        acc_next = sum[15:0];
        ovf_next = ovf | sum[16];   // sticky carry out of bit 15
    end

    // NOTE: the accumulator is an ordinary register, not a memory array, so it
    // is reset with the rest of the state; results must read 0 out of reset.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            acc   <= '0;
            ovf   <= 1'b0;
            count <= '0;
        end else if (clear) begin
            acc   <= '0;
            ovf   <= 1'b0;
            count <= '0;
        end else if (en) begin
            acc   <= acc_next;
            ovf   <= ovf_next;
            count <= count + CNT_W'(1);
        end
    end
endmodule

module mac_sched #(
    parameter int NREQ  = 4,
    parameter int LEN_W = 8,
    parameter int ID_W  = 2
) (
    input  logic                  clk,
    input  logic                  aclr_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*LEN_W-1:0] len,
    output logic [NREQ-1:0]       gnt,
    output logic                  busy,
    input  logic [7:0]            op_a,
    input  logic [7:0]            op_b,
    input  logic                  op_valid,
    output logic                  op_ready,
    output logic                  res_valid,
    output logic [15:0]           res_data,
    output logic [ID_W-1:0]       res_id,
    output logic                  res_ovf
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    // Arbiter outputs
    logic             pick_found;
    logic [ID_W-1:0]  pick_idx;
    logic [LEN_W-1:0] pick_len;

    // Job context latched at grant time
    logic [ID_W-1:0]  rr_q;
    logic [ID_W-1:0]  idx_q;
    logic [LEN_W-1:0] len_q;
    logic [NREQ-1:0]  gnt_q;

    // Datapath interface
    logic             dp_clear;
    logic             beat;
    logic             last_beat;
    logic [15:0]      dp_acc;
    logic             dp_ovf;
    logic [LEN_W-1:0] dp_count;
    logic [15:0]      dp_acc_next;
    logic             dp_ovf_next;

    // Held result
    logic [15:0]      res_data_q;
    logic [ID_W-1:0]  res_id_q;
    logic             res_ovf_q;

    mac_sched_arb #(
        .NREQ  (NREQ),
        .LEN_W (LEN_W),
        .ID_W  (ID_W)
    ) u_arb (
        .req     (req),
        .len     (len),
        .ptr     (rr_q),
        .found   (pick_found),
        .idx     (pick_idx),
        .sel_len (pick_len)
    );

    mac_sched_dp #(
        .CNT_W (LEN_W)
    ) u_dp (
        .clk      (clk),
        .aclr_n   (aclr_n),
        .clear    (dp_clear),
        .en       (beat),
        .a        (op_a),
        .b        (op_b),
        .acc      (dp_acc),
        .ovf      (dp_ovf),
        .count    (dp_count),
        .acc_next (dp_acc_next),
        .ovf_next (dp_ovf_next)
    );

    // A beat is the last one when count==len-1 before it is accepted; len==0
    // never reaches RUN, so len_q-1 cannot underflow here.
    assign dp_clear  = (state_q == S_CLEAR);
    assign beat      = (state_q == S_RUN) && op_valid;
    assign last_beat = beat && (dp_count == len_q - LEN_W'(1));

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values and updates together.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        busy      = 1'b1;
        op_ready  = 1'b0;
        res_valid = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (pick_found) begin
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                state_d = (len_q == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                op_ready = 1'b1;
                if (last_beat) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                res_valid = 1'b1;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Grant context: req/len are looked at only in IDLE, so requesters may
    // change them freely while a job runs.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            rr_q  <= '0;
            idx_q <= '0;
            len_q <= '0;
            gnt_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pick_found) begin
                        idx_q <= pick_idx;
                        len_q <= pick_len;
                        gnt_q <= NREQ'(1) << pick_idx;
                    end
                end
                S_DONE: begin
                    gnt_q <= '0;
                    rr_q  <= (idx_q == ID_W'(NREQ - 1)) ? '0 : idx_q + ID_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Result registers load on the edge into DONE so they are valid with the
    // strobe (last product included) and hold until the next job finishes.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            res_data_q <= '0;
            res_id_q   <= '0;
            res_ovf_q  <= 1'b0;
        end else if ((state_q == S_CLEAR) && (len_q == '0)) begin
            res_data_q <= '0;
            res_id_q   <= idx_q;
            res_ovf_q  <= 1'b0;
        end else if (last_beat) begin
            res_data_q <= dp_acc_next;
            res_id_q   <= idx_q;
            res_ovf_q  <= dp_ovf_next;
        end
    end

    assign gnt      = gnt_q;
    assign res_data = res_data_q;
    assign res_id   = res_id_q;
    assign res_ovf  = res_ovf_q;

    // Accumulator state is observed only through the captured result.
    logic unused_dp;
    assign unused_dp = ^{dp_acc, dp_ovf};

endmodule

// File: tb/tb_mac_sched.sv
// -----------------------------------------------------------------------------
// tb_mac_sched -- self-checking bench for mac_sched.
//
// A scoreboard holds the expected result of each job, computed from the
// operand tables as a plain dot product (wrap and overflow derived from the
// full-precision sum), with the grant order predicted by a round-robin pick
// over the request vector. A negedge monitor compares every cycle; directed
// tests pin the model with hand-computed literals and cycle latencies.
// -----------------------------------------------------------------------------
module tb_mac_sched;
    localparam int NREQ  = 4;
    localparam int LEN_W = 8;
    localparam int ID_W  = 2;

    logic                  clk = 1'b0;
    logic                  aclr_n;
    logic [NREQ-1:0]       req;
    logic [NREQ*LEN_W-1:0] len;
    logic [NREQ-1:0]       gnt;
    logic                  busy;
    logic [7:0]            op_a;
    logic [7:0]            op_b;
    logic                  op_valid;
    logic                  op_ready;
    logic                  res_valid;
    logic [15:0]           res_data;
    logic [ID_W-1:0]       res_id;
    logic                  res_ovf;

    mac_sched #(
        .NREQ  (NREQ),
        .LEN_W (LEN_W),
        .ID_W  (ID_W)
    ) dut (
        .clk       (clk),
        .aclr_n    (aclr_n),
        .req       (req),
        .len       (len),
        .gnt       (gnt),
        .busy      (busy),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_id    (res_id),
        .res_ovf   (res_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [15:0] data;
        logic        ovf;
    } exp_t;

    int              tests = 0;
    int              fails = 0;
    int              cyc   = 0;
    int              res_cnt = 0;
    int              last_res_cyc = 0;
    logic [15:0]     last_data = '0;
    int              last_id = 0;
    logic            last_ovf = 1'b0;
    int              seen_ids[$];
    bit              saw_ready = 1'b0;
    exp_t            exp_q[$];
    exp_t            cur_e;
    logic [15:0]     hold_data = '0;
    logic [ID_W-1:0] hold_id = '0;
    logic            hold_ovf = 1'b0;
    int              m_rr = 0;
    int              ja[NREQ][8];
    int              jb[NREQ][8];

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Round-robin prediction: first set bit from ptr upward, wrapping.
    function automatic int pick(input logic [NREQ-1:0] r, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = (ptr + k) % NREQ;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    // Expected result: exact dot product, low 16 bits, overflow if the exact
    // sum ever exceeded 16 bits (products are non-negative, so the final sum
    // decides it).
    function automatic exp_t model_job(input int id, input int n);
        exp_t e;
        int   s;
        s = 0;
        for (int k = 0; k < n; k++) s += ja[id][k] * jb[id][k];
        e.id   = id;
        e.data = 16'(s);
        e.ovf  = (s > 65535);
        return e;
    endfunction

    // Every-cycle monitor against the scoreboard.
    always @(negedge clk) begin
        if (!aclr_n) begin
            hold_data = '0;
            hold_id   = '0;
            hold_ovf  = 1'b0;
        end else begin
            if (op_ready) saw_ready = 1'b1;
            check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
            check("busy_vs_gnt", 32'(busy), 32'(|gnt));
            if (res_valid) begin
                res_cnt++;
                last_res_cyc = cyc;
                last_data    = res_data;
                last_id      = int'(res_id);
                last_ovf     = res_ovf;
                seen_ids.push_back(int'(res_id));
                if (exp_q.size() == 0) begin
                    check("unexpected_res_valid", 32'd1, 32'd0);
                end else begin
                    cur_e     = exp_q.pop_front();
                    hold_data = cur_e.data;
                    hold_id   = ID_W'(cur_e.id);
                    hold_ovf  = cur_e.ovf;
                end
            end
            check("res_data", 32'(res_data), 32'(hold_data));
            check("res_id", 32'(res_id), 32'(hold_id));
            check("res_ovf", 32'(res_ovf), 32'(hold_ovf));
        end
    end

    // Acts as the granted requester: waits for gnt, streams n pairs (optional
    // bubble run, optional reset after abort_after beats), then offers one
    // surplus pair in the DONE cycle and sets req to r_after.
    task automatic serve_job(input int id, input int n, input int bubble_at, input int bubble_n,
                             input int abort_after, input logic [NREQ-1:0] r_after,
                             input bit scramble, output int g_c, output int d_c);
        int   waited, beats, gap, spin;
        logic rdy;
        waited = 0;
        while (gnt == '0 && waited < 50) begin
            tick();
            waited++;
        end
        check("gnt_seen", 32'(gnt != '0), 32'd1);
        g_c = cyc;
        d_c = cyc;
        if (gnt == '0) return;
        check("gnt_id", 32'(gnt), 32'd1 << id);
        if (scramble) begin
            req = '1;
            len = '1;
        end
        beats = 0;
        gap   = 0;
        spin  = 0;
        if (n == 0) begin
            check("ready_in_clear", 32'(op_ready), 32'd0);
            tick();
        end
        while (beats < n && spin < 100) begin
            if (beats == bubble_at && gap < bubble_n) begin
                op_valid = 1'b0;
                gap++;
            end else begin
                op_valid = 1'b1;
                op_a     = 8'(ja[id][beats]);
                op_b     = 8'(jb[id][beats]);
            end
            rdy = op_ready;
            tick();
            spin++;
            if (op_valid && rdy) begin
                beats++;
                if (beats == abort_after) begin
                    op_valid = 1'b0;
                    #1 aclr_n = 1'b0;
                    #1;
                    check("rst_gnt", 32'(gnt), 32'd0);
                    check("rst_busy", 32'(busy), 32'd0);
                    check("rst_ready", 32'(op_ready), 32'd0);
                    check("rst_res_data", 32'(res_data), 32'd0);
                    check("rst_res_valid", 32'(res_valid), 32'd0);
                    d_c = cyc;
                    return;
                end
            end
        end
        check("beats_done", beats, n);
        d_c      = cyc;
        req      = r_after;
        op_valid = 1'b1;
        op_a     = 8'hFF;
        op_b     = 8'hFF;
        check("ready_after_last", 32'(op_ready), 32'd0);
        tick();
        op_valid = 1'b0;
    endtask

    task automatic do_job(input logic [NREQ-1:0] r_hold, input logic [NREQ-1:0] r_after,
                          input int bubble_at, input int bubble_n, input bit scramble,
                          output int id, output int g_c, output int d_c);
        int n;
        id = pick(r_hold, m_rr);
        n  = int'(len[id*LEN_W +: LEN_W]);
        exp_q.push_back(model_job(id, n));
        req = r_hold;
        serve_job(id, n, bubble_at, bubble_n, -1, r_after, scramble, g_c, d_c);
        m_rr = (id + 1) % NREQ;
    endtask

    initial begin
        int id, g, d, t0, rc, prev_d;
        int exp_rr[5];
        exp_rr = '{0, 1, 2, 3, 0};
        aclr_n = 1'b0;
        req = '0; len = '0; op_a = '0; op_b = '0; op_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_gnt", 32'(gnt), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_ready", 32'(op_ready), 32'd0);
        check("reset_res_valid", 32'(res_valid), 32'd0);
        check("reset_res_data", 32'(res_data), 32'd0);
        check("reset_res_id", 32'(res_id), 32'd0);
        check("reset_res_ovf", 32'(res_ovf), 32'd0);
        aclr_n = 1'b1;
        tick();

        // Single job, len 3; req/len scribbled mid-job must be ignored.
        ja[0][0] = 3; jb[0][0] = 4;
        ja[0][1] = 5; jb[0][1] = 6;
        ja[0][2] = 7; jb[0][2] = 8;
        len = '0; len[0 +: LEN_W] = 8'd3;
        t0 = cyc;
        do_job(4'b0001, 4'b0000, -1, 0, 1'b1, id, g, d);
        check("single_gnt_lat", g - t0, 1);
        check("single_res_lat", last_res_cyc - g, 4);
        check("single_data", 32'(last_data), 32'h0062);
        check("single_id", last_id, 0);
        check("single_ovf", 32'(last_ovf), 32'd0);

        // Same job with a two-cycle bubble after the first beat.
        len = '0; len[0 +: LEN_W] = 8'd3;
        do_job(4'b0001, 4'b0000, 1, 2, 1'b0, id, g, d);
        check("bubble_res_lat", last_res_cyc - g, 6);
        check("bubble_data", 32'(last_data), 32'h0062);

        // Overflow, then a small job that must see ovf cleared.
        ja[0][0] = 255; jb[0][0] = 255;
        ja[0][1] = 255; jb[0][1] = 255;
        len = '0; len[0 +: LEN_W] = 8'd2;
        do_job(4'b0001, 4'b0000, -1, 0, 1'b0, id, g, d);
        check("ovf_data", 32'(last_data), 32'hFC02);
        check("ovf_flag", 32'(last_ovf), 32'd1);
        ja[0][0] = 1; jb[0][0] = 1;
        len = '0; len[0 +: LEN_W] = 8'd1;
        do_job(4'b0001, 4'b0000, -1, 0, 1'b0, id, g, d);
        check("post_ovf_data", 32'(last_data), 32'h0001);
        check("post_ovf_flag", 32'(last_ovf), 32'd0);

        // Zero-length job on requester 3.
        len = '0;
        saw_ready = 1'b0;
        do_job(4'b1000, 4'b0000, -1, 0, 1'b0, id, g, d);
        check("zero_no_ready", 32'(saw_ready), 32'd0);
        check("zero_res_lat", last_res_cyc - g, 1);
        check("zero_data", 32'(last_data), 32'd0);
        check("zero_id", last_id, 3);

        // Round robin with all requesters held high, every len 1.
        for (int i = 0; i < NREQ; i++) begin
            ja[i][0] = i + 2;
            jb[i][0] = i + 3;
            len[i*LEN_W +: LEN_W] = 8'd1;
        end
        seen_ids.delete();
        prev_d = 0;
        for (int k = 0; k < 5; k++) begin
            do_job(4'b1111, (k == 4) ? 4'b0000 : 4'b1111, -1, 0, 1'b0, id, g, d);
            if (k > 0) check("rr_regrant_lat", g - prev_d, 2);
            prev_d = d;
        end
        check("rr_count", seen_ids.size(), 5);
        for (int k = 0; k < 5; k++) begin
            if (k < seen_ids.size()) check("rr_seq", seen_ids[k], exp_rr[k]);
        end
        do_job(4'b0010, 4'b0000, -1, 0, 1'b0, id, g, d);
        check("rr_grant1", last_id, 1);
        do_job(4'b0110, 4'b0000, -1, 0, 1'b0, id, g, d);
        check("rr_after1", last_id, 2);

        // Reset after 2 of 5 beats on requester 2.
        for (int k = 0; k < 5; k++) begin
            ja[2][k] = 1;
            jb[2][k] = 1;
        end
        len = '0; len[2*LEN_W +: LEN_W] = 8'd5;
        req = 4'b0100;
        rc  = res_cnt;
        serve_job(pick(4'b0100, m_rr), 5, -1, 0, 2, 4'b0000, 1'b0, g, d);
        req = '0;
        repeat (2) tick();
        aclr_n = 1'b1;
        m_rr = 0;
        tick();
        check("abort_no_res", res_cnt, rc);

        // Fresh job after reset: pointer back at 0 picks requester 1 of {1,3}.
        ja[1][0] = 2; jb[1][0] = 3;
        len = '0; len[1*LEN_W +: LEN_W] = 8'd1; len[3*LEN_W +: LEN_W] = 8'd1;
        t0 = cyc;
        do_job(4'b1010, 4'b0000, -1, 0, 1'b0, id, g, d);
        check("post_rst_gnt_lat", g - t0, 1);
        check("post_rst_id", last_id, 1);
        check("post_rst_data", 32'(last_data), 32'd6);
        check("scoreboard_empty", exp_q.size(), 0);

        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1, "watchdog");
    end

endmodule
